// File: rtl/spi_reg_ctrl_if.sv
// Bus bundle between a register-access requester and spi_reg_ctrl, including
// the frame-engine side (fs/fd handshake) and a debug view of the sequencer state.
//
// Handshake rules:
//   request : a request transfers on a rising clk edge where req_valid & req_ready
//             are both high; req_ready is high only while the sequencer is idle, so
//             a held req_valid waits (no queueing) and its fields are don't-care
//             after the transfer edge.
//   response: rsp_valid is a one-cycle pulse with no back-pressure; rsp_rdata and
//             rsp_stat hold their values until the next pulse.
//   engine  : spi_fs is raised to start a frame and held with spi_txd stable until
//             spi_fd is seen high; spi_fs then drops and is not raised again until
//             spi_fd has been seen low.
interface spi_reg_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [6:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [7:0]  rsp_stat;
  logic        busy;
  logic        spi_fs;
  logic        spi_fd;
  logic [15:0] spi_txd;
  logic [15:0] spi_rxd;
  logic [2:0]  dbg_state;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, spi_fd, spi_rxd,
    output req_ready, rsp_valid, rsp_rdata, rsp_stat, busy, spi_fs, spi_txd, dbg_state
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, spi_fd, spi_rxd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_stat, busy, spi_fs, spi_txd, dbg_state
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Register-access sequencer in front of the 16-bit SPI frame engine.
// A write is one frame {0, addr, wdata}; a read is a command frame {1, addr, 8'h00}
// followed by a NOP frame whose low byte returns the read data. The status byte is
// the upper byte received during the command frame.
module spi_reg_ctrl #(
  parameter int unsigned GAP_CYC  = 8,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  spi_reg_ctrl_if.slave bus
);

  // A zero gap would let spi_fs re-assert back-to-back, so it is stretched to one cycle.
  localparam int unsigned GAP_EFF  = (GAP_CYC == 0) ? 1 : GAP_CYC;
  localparam logic [7:0]  GAP_LAST = 8'(GAP_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_CREL = 3'd2,
    S_GAP1 = 3'd3,
    S_NOP  = 3'd4,
    S_NREL = 3'd5,
    S_GAP2 = 3'd6,
    S_DONE = 3'd7
  } state_e;

  state_e      state_q,     state_d;
  logic [7:0]  gap_cnt_q,   gap_cnt_d;
  logic        rw_q,        rw_d;
  logic        spi_fs_q,    spi_fs_d;
  logic [15:0] spi_txd_q,   spi_txd_d;
  logic [7:0]  stat_buf_q,  stat_buf_d;
  logic [7:0]  rdata_buf_q, rdata_buf_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic [7:0]  rsp_stat_q,  rsp_stat_d;

  // Next-state and datapath: frames are captured into buffers and only published on
  // the DONE entry, so the response outputs stay stable between rsp_valid pulses.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    rw_d        = rw_q;
    spi_txd_d   = spi_txd_q;
    stat_buf_d  = stat_buf_q;
    rdata_buf_d = rdata_buf_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_stat_d  = rsp_stat_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          rw_d      = bus.req_rw;
          spi_txd_d = {bus.req_rw, bus.req_addr, bus.req_rw ? 8'h00 : bus.req_wdata};
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (bus.spi_fd) begin
          stat_buf_d = bus.spi_rxd[15:8];
          state_d    = S_CREL;
        end
      end
      S_CREL: begin
        if (!bus.spi_fd) state_d = S_GAP1;
      end
      S_GAP1: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (rw_q) begin
            spi_txd_d = NOP_WORD;
            state_d   = S_NOP;
          end else begin
            state_d   = S_DONE;
          end
        end
      end
      S_NOP: begin
        if (bus.spi_fd) begin
          rdata_buf_d = bus.spi_rxd[7:0];
          state_d     = S_NREL;
        end
      end
      S_NREL: begin
        if (!bus.spi_fd) state_d = S_GAP2;
      end
      S_GAP2: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Gap counter restarts on every state change and only advances in the gap states.
    if (state_d != state_q) begin
      gap_cnt_d = 8'h00;
    end else if (state_q == S_GAP1 || state_q == S_GAP2) begin
      gap_cnt_d = gap_cnt_q + 8'd1;
    end

    // fs rises the cycle after CMD/NOP entry and drops the cycle after fd is seen.
    spi_fs_d = (state_q == S_CMD || state_q == S_NOP) && !bus.spi_fd;

    rsp_valid_d = (state_d == S_DONE);
    if (state_d == S_DONE) begin
      rsp_stat_d  = stat_buf_q;
      rsp_rdata_d = rw_q ? rdata_buf_q : 8'h00;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= 8'h00;
      rw_q        <= 1'b0;
      spi_fs_q    <= 1'b0;
      spi_txd_q   <= 16'h0000;
      stat_buf_q  <= 8'h00;
      rdata_buf_q <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_stat_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      rw_q        <= rw_d;
      spi_fs_q    <= spi_fs_d;
      spi_txd_q   <= spi_txd_d;
      stat_buf_q  <= stat_buf_d;
      rdata_buf_q <= rdata_buf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_stat_q  <= rsp_stat_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.spi_fs    = spi_fs_q;
  assign bus.spi_txd   = spi_txd_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_stat  = rsp_stat_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: engine model on the fs/fd handshake, response scoreboard,
// vector table for single transactions, hand sequences for multi-cycle corners.
module tb_spi_reg_ctrl;

  localparam int GAP = 8;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_GAP1 = 3'd3;
  localparam logic [2:0] ST_NOP  = 3'd4;
  localparam logic [2:0] ST_GAP2 = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_reg_ctrl_if bus ();
  spi_reg_ctrl_if bus0 ();

  spi_reg_ctrl #(.GAP_CYC(GAP), .NOP_WORD(16'h0000)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  spi_reg_ctrl #(.GAP_CYC(0), .NOP_WORD(16'h0000)) u_dut_g0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: actual=event required=no_event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];        // {stat, rdata} per transaction
  logic [15:0] exp_frame_q[$];  // expected spi_txd per frame
  logic [15:0] rxd_q[$];        // word the engine returns per frame
  int outstanding = 0;

  // ---------------- engine model (main DUT) ----------------
  int fd_delay = 2;
  int fd_hold  = 0;
  int eng_st   = 0;
  int eng_cnt  = 0;
  int eng_low  = 0;
  bit eng_prev = 1'b0;
  logic [15:0] eng_word;
  logic [15:0] eng_txd;

  always @(negedge clk) begin
    if (rst) begin
      eng_st       = 0;
      eng_low      = 0;
      eng_prev     = 1'b0;
      bus.spi_fd   = 1'b0;
      bus.spi_rxd  = 16'h0000;
    end else begin
      case (eng_st)
        0: begin
          if (bus.spi_fs) begin
            if (eng_prev) check("fs_low_gap", 32'(eng_low >= GAP), 32'd1);
            eng_prev = 1'b1;
            eng_low  = 0;
            eng_txd  = bus.spi_txd;
            if (exp_frame_q.size() == 0) fail_note("unexpected_frame");
            else check("frame_txd", bus.spi_txd, exp_frame_q.pop_front());
            eng_word = (rxd_q.size() != 0) ? rxd_q.pop_front() : 16'h0000;
            eng_cnt  = fd_delay;
            eng_st   = 1;
          end else begin
            eng_low++;
          end
        end
        1: begin
          if (!bus.spi_fs) fail_note("fs_dropped_before_fd");
          if (bus.spi_txd !== eng_txd) fail_note("txd_changed_in_frame");
          if (eng_cnt == 0) begin
            bus.spi_fd  = 1'b1;
            bus.spi_rxd = eng_word;
            eng_st      = 2;
          end else begin
            eng_cnt--;
          end
        end
        2: begin
          if (!bus.spi_fs) begin
            eng_low = 1;
            if (fd_hold == 0) begin
              bus.spi_fd = 1'b0;
              eng_st     = 0;
            end else begin
              eng_cnt = fd_hold;
              eng_st  = 3;
            end
          end
        end
        default: begin
          if (bus.spi_fs) fail_note("fs_during_fd_hold");
          eng_low++;
          eng_cnt--;
          if (eng_cnt == 0) begin
            bus.spi_fd = 1'b0;
            eng_st     = 0;
          end
        end
      endcase
    end
  end

  // ---------------- engine model (GAP_CYC=0 DUT): fd echoes fs ----------------
  always @(negedge clk) begin
    if (rst) begin
      bus0.spi_fd  = 1'b0;
      bus0.spi_rxd = 16'h0000;
    end else begin
      bus0.spi_fd  = bus0.spi_fs;
      bus0.spi_rxd = 16'h5A00;
    end
  end

  // ---------------- monitor ----------------
  int gap_run = 0;
  bit after_done = 1'b0;
  logic [2:0] prev_state = ST_IDLE;
  logic [15:0] exp_rsp;

  always @(negedge clk) begin
    if (rst) begin
      gap_run     = 0;
      after_done  = 1'b0;
      outstanding = 0;
      prev_state  = ST_IDLE;
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        if (outstanding != 0) fail_note("accept_while_outstanding");
        outstanding++;
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail_note("unexpected_rsp_valid");
        end else begin
          exp_rsp = exp_q.pop_front();
          check("rsp_stat", bus.rsp_stat, exp_rsp[15:8]);
          check("rsp_rdata", bus.rsp_rdata, exp_rsp[7:0]);
        end
        if (outstanding > 0) outstanding--;
        after_done = 1'b1;
      end else if (after_done) begin
        check("busy_after_done", bus.busy, 1'b0);
        check("ready_after_done", bus.req_ready, 1'b1);
        after_done = 1'b0;
      end
      if (bus.dbg_state == ST_GAP1 || bus.dbg_state == ST_GAP2) begin
        gap_run++;
      end else if (gap_run != 0) begin
        check("gap_len", gap_run, GAP);
        gap_run = 0;
      end
      if (((bus.dbg_state == ST_CMD && prev_state != ST_CMD) ||
           (bus.dbg_state == ST_NOP && prev_state != ST_NOP)) && bus.spi_fd)
        fail_note("fd_high_on_frame_entry");
      prev_state = bus.dbg_state;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                      input logic [15:0] rx_cmd, input logic [15:0] rx_nop,
                      input logic [15:0] exp_txd, input logic [7:0] exp_stat,
                      input logic [7:0] exp_rdata, input bit keep_valid);
    int n;
    exp_frame_q.push_back(exp_txd);
    rxd_q.push_back(rx_cmd);
    if (rw) begin
      exp_frame_q.push_back(16'h0000);
      rxd_q.push_back(rx_nop);
    end
    exp_q.push_back({exp_stat, exp_rdata});
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) fail_note("accept_timeout");
    tick();
    if (!keep_valid) begin
      bus.req_valid = 1'b0;
      bus.req_rw    = $urandom_range(0, 1);
      bus.req_addr  = 7'($urandom_range(0, 127));
      bus.req_wdata = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((outstanding != 0 || exp_q.size() != 0 || bus.busy) && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) fail_note("completion_timeout");
    repeat (2) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] rx_cmd;
    logic [15:0] rx_nop;
    int          delay;
    logic [15:0] exp_txd;
    logic [7:0]  exp_stat;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int g1_cnt;
    int rsp_cnt;
    logic [15:0] txd_seen;

    vecs[0] = '{1'b0, 7'h05, 8'h12, 16'hA55A, 16'h0000, 340, 16'h0512, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 7'h7F, 8'h00, 16'h3C00, 16'h00E7, 3,   16'hFF00, 8'h3C, 8'hE7};
    vecs[2] = '{1'b0, 7'h2A, 8'hC3, 16'h1234, 16'h0000, 7,   16'h2AC3, 8'h12, 8'h00};
    vecs[3] = '{1'b1, 7'h01, 8'h00, 16'h77FF, 16'hABCD, 1,   16'h8100, 8'h77, 8'hCD};
    vecs[4] = '{1'b0, 7'h7F, 8'hFF, 16'hFFFF, 16'h0000, 0,   16'h7FFF, 8'hFF, 8'h00};
    vecs[5] = '{1'b1, 7'h00, 8'h55, 16'h0000, 16'h1280, 5,   16'h8000, 8'h00, 8'h80};

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_rw     = 1'b0;
    bus.req_addr   = 7'h00;
    bus.req_wdata  = 8'h00;
    bus0.req_valid = 1'b0;
    bus0.req_rw    = 1'b0;
    bus0.req_addr  = 7'h00;
    bus0.req_wdata = 8'h00;
    repeat (3) tick();

    check("rst_spi_fs",    bus.spi_fs,    1'b0);
    check("rst_spi_txd",   bus.spi_txd,   16'h0000);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
    check("rst_rsp_stat",  bus.rsp_stat,  8'h00);
    check("rst_busy",      bus.busy,      1'b0);
    check("rst_req_ready", bus.req_ready, 1'b1);
    rst = 1'b0;
    repeat (2) tick();

    // table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      fd_delay = vecs[i].delay;
      send(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rx_cmd, vecs[i].rx_nop,
           vecs[i].exp_txd, vecs[i].exp_stat, vecs[i].exp_rdata, 1'b0);
      wait_idle();
    end

    // back-to-back writes with req_valid held high
    fd_delay = 4;
    send(1'b0, 7'h33, 8'h44, 16'h9900, 16'h0000, 16'h3344, 8'h99, 8'h00, 1'b1);
    send(1'b0, 7'h34, 8'h01, 16'h8800, 16'h0000, 16'h3401, 8'h88, 8'h00, 1'b0);
    wait_idle();

    // engine holds fd high 20 cycles after fs drops, on both frames of a read
    fd_hold = 20;
    send(1'b1, 7'h42, 8'h00, 16'h6600, 16'h00B4, 16'hC200, 8'h66, 8'hB4, 1'b0);
    wait_idle();
    fd_hold = 0;

    // reset pulsed while the command frame of a read is in flight
    fd_delay = 50;
    send(1'b1, 7'h11, 8'h00, 16'hEE00, 16'h00DD, 16'h9100, 8'hEE, 8'hDD, 1'b0);
    n = 0;
    while (!bus.spi_fs && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) fail_note("fs_rise_timeout");
    repeat (3) tick();
    rst = 1'b1;
    exp_q.delete();
    exp_frame_q.delete();
    rxd_q.delete();
    @(negedge clk);
    check("midrst_spi_fs", bus.spi_fs, 1'b0);
    check("midrst_busy",   bus.busy,   1'b0);
    check("midrst_txd",    bus.spi_txd, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    fd_delay = 3;
    send(1'b0, 7'h12, 8'h34, 16'h5500, 16'h0000, 16'h1234, 8'h55, 8'h00, 1'b0);
    wait_idle();

    // GAP_CYC=0 build: GAP1 lasts one cycle, response intact
    bus0.req_valid = 1'b1;
    bus0.req_rw    = 1'b0;
    bus0.req_addr  = 7'h10;
    bus0.req_wdata = 8'h99;
    tick();
    bus0.req_valid = 1'b0;
    g1_cnt   = 0;
    rsp_cnt  = 0;
    txd_seen = 16'h0000;
    n = 0;
    while (rsp_cnt == 0 && n < 200) begin
      if (bus0.dbg_state == ST_GAP1) g1_cnt++;
      if (bus0.spi_fs) txd_seen = bus0.spi_txd;
      if (bus0.rsp_valid) begin
        rsp_cnt++;
        check("g0_rsp_stat",  bus0.rsp_stat,  8'h5A);
        check("g0_rsp_rdata", bus0.rsp_rdata, 8'h00);
      end
      tick();
      n++;
    end
    if (n >= 200) fail_note("g0_completion_timeout");
    repeat (3) begin
      if (bus0.rsp_valid) rsp_cnt++;
      tick();
    end
    check("g0_gap1_cycles", g1_cnt, 1);
    check("g0_frame_txd", txd_seen, 16'h1099);
    check("g0_rsp_count", rsp_cnt, 1);
    check("g0_busy_after", bus0.busy, 1'b0);

    check("frames_left", exp_frame_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // overall time bound
  initial begin
    #3_000_000;
    fail_note("global_timeout");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
